hidden_layer: RTL and testbench

HIDDEN_LAYER -- requirements
Module: hidden_layer

---
 rtl/hidden_layer_if.sv | 26 ++
 rtl/hidden_layer.sv | 130 +++++++++++++
 tb/tb_hidden_layer.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hidden_layer_if.sv
// Bus bundle for hidden_layer: evaluation control, input vector,
// per-neuron bias/weight fetch, and the packed neuron results.
interface hidden_layer_if #(
  parameter int N_NEURON = 10,
  parameter int N_IN     = 4
);
  logic                  start;
  logic [8*N_IN-1:0]     in_vec;
  logic [7:0]            b;
  logic [7:0]            w;
  logic [3:0]            neuron_idx;
  logic [2:0]            tap_idx;
  logic                  busy;
  logic [8*N_NEURON-1:0] outreg;
  logic                  done;

  modport master (
    output start, in_vec, b, w,
    input  neuron_idx, tap_idx, busy, outreg, done
  );

  modport slave (
    input  start, in_vec, b, w,
    output neuron_idx, tap_idx, busy, outreg, done
  );
endinterface

// File: rtl/hidden_layer.sv
// Sequential fully-connected hidden layer: one MAC per cycle, bias/weights
// fetched by index. Define HIDDEN_RELU_EN to clamp results to 0..127 (ReLU).
module hidden_layer #(
  parameter int N_NEURON = 10,
  parameter int N_IN     = 4,
  parameter int SHIFT    = 4
) (
  input logic           clk,
  input logic           rst_n,
  hidden_layer_if.slave bus
);

  // Accumulator wide enough for the bias term and N_IN full-scale products.
  localparam int PROD_MSB = 14 + $clog2(N_IN);
  localparam int BIAS_MSB = 7 + SHIFT;
  localparam int NEED_W   = ((PROD_MSB > BIAS_MSB) ? PROD_MSB : BIAS_MSB) + 2;
  localparam int ACC_W    = (NEED_W > 19) ? NEED_W : 19;

  localparam logic signed [ACC_W-1:0] POS_MAX = ACC_W'(127);
  localparam logic signed [ACC_W-1:0] NEG_MIN = ACC_W'(-128);

  typedef enum logic [2:0] {IDLE, BIAS, MAC, STORE, DONE} state_t;

  state_t state, state_nxt;

  logic [8*N_IN-1:0]       in_lat;
  logic [8*N_NEURON-1:0]   outreg;
  logic signed [ACC_W-1:0] acc;
  logic                    done;
  logic [3:0]              nidx;
  logic [2:0]              tidx;

  logic signed [7:0]       tap_x;
  logic signed [15:0]      prod;
  logic signed [ACC_W-1:0] prod_ext;
  logic signed [ACC_W-1:0] bias_ext;
  logic signed [ACC_W-1:0] shifted;
  logic [7:0]              clamped;
  logic                    last_tap;
  logic                    last_neuron;

  assign last_tap    = (tidx == 3'(N_IN - 1));
  assign last_neuron = (nidx == 4'(N_NEURON - 1));

  assign tap_x    = in_lat[int'(tidx)*8 +: 8];
  assign prod     = $signed(bus.w) * tap_x;
  assign prod_ext = ACC_W'(prod);
  assign bias_ext = ACC_W'($signed(bus.b)) <<< SHIFT;
  assign shifted  = acc >>> SHIFT;

  // NOTE: every branch of an always_comb must see an assignment, so a default
  // goes first; otherwise a latch is inferred to hold the old value.
  always_comb begin
    clamped = shifted[7:0];
    if (shifted > POS_MAX) begin
      clamped = 8'h7F;
`ifdef HIDDEN_RELU_EN
    end else if (shifted < '0) begin
      clamped = 8'h00;
`else
    end else if (shifted < NEG_MIN) begin
      clamped = 8'h80;
`endif
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (bus.start) state_nxt = BIAS;
      BIAS:       state_nxt = MAC;
      MAC:        if (last_tap) state_nxt = STORE;
      STORE:      state_nxt = last_neuron ? DONE : BIAS;
      default:    state_nxt = IDLE;
    endcase
  end

  // NOTE: outreg is a flop vector, not a RAM macro, so it is cleared by reset;
  // this guarantees no stale partial result survives an aborted run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_lat <= '0;
      outreg <= '0;
      acc    <= '0;
      done   <= 1'b0;
      nidx   <= '0;
      tidx   <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            in_lat <= bus.in_vec;
            outreg <= '0;
            done   <= 1'b0;
            nidx   <= '0;
            tidx   <= '0;
          end
        end
        BIAS: begin
          acc  <= bias_ext;
          tidx <= '0;
        end
        MAC: begin
          acc  <= acc + prod_ext;
          tidx <= last_tap ? 3'd0 : tidx + 3'd1;
        end
        STORE: begin
          outreg[int'(nidx)*8 +: 8] <= clamped;
          if (last_neuron) done <= 1'b1;
          else             nidx <= nidx + 4'd1;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy       = (state == BIAS) || (state == MAC) || (state == STORE);
  assign bus.done       = done;
  assign bus.outreg     = outreg;
  assign bus.neuron_idx = nidx;
  assign bus.tap_idx    = tidx;

endmodule

// File: tb/tb_hidden_layer.sv
// Self-checking bench for hidden_layer: directed corner cases plus randomized
// runs scored against an integer-arithmetic model of the layer.
module tb_hidden_layer;
  localparam int NN  = 10;
  localparam int NI  = 4;
  localparam int SH  = 4;
  localparam int LAT = NN * (NI + 2);

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  hidden_layer_if #(.N_NEURON(NN), .N_IN(NI)) bus ();

  hidden_layer #(.N_NEURON(NN), .N_IN(NI), .SHIFT(SH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int vectors = 0;
  int errors  = 0;

  logic signed [7:0] x_mem [NI];
  logic signed [7:0] b_mem [16];
  logic signed [7:0] w_mem [16][8];

  // Bias/weight memory answering the block's current address.
  always_comb begin
    bus.b = b_mem[bus.neuron_idx];
    bus.w = w_mem[bus.neuron_idx][bus.tap_idx];
  end

  task automatic load_uniform(input int x, input int w, input int b);
    for (int i = 0; i < NI; i++) x_mem[i] = 8'(x);
    for (int n = 0; n < 16; n++) begin
      b_mem[n] = 8'(b);
      for (int t = 0; t < 8; t++) w_mem[n][t] = 8'(w);
    end
  endtask

  task automatic load_random();
    for (int i = 0; i < NI; i++) x_mem[i] = 8'($urandom);
    for (int n = 0; n < 16; n++) begin
      b_mem[n] = 8'($urandom);
      for (int t = 0; t < 8; t++) w_mem[n][t] = 8'($urandom);
    end
  endtask

  task automatic drive_in_vec();
    for (int i = 0; i < NI; i++) bus.in_vec[i*8 +: 8] = x_mem[i];
  endtask

  // Reference: y_n = clamp(floor((b_n*2^SH + sum_t w_nt*x_t) / 2^SH)).
  function automatic logic [8*NN-1:0] model();
    logic [8*NN-1:0] r;
    int acc, y;
    r = '0;
    for (int n = 0; n < NN; n++) begin
      acc = int'(b_mem[n]) * (1 << SH);
      for (int t = 0; t < NI; t++) acc += int'(w_mem[n][t]) * int'(x_mem[t]);
      y = acc >>> SH;
      if (y > 127) y = 127;
`ifdef HIDDEN_RELU_EN
      if (y < 0) y = 0;
`else
      if (y < -128) y = -128;
`endif
      r[n*8 +: 8] = 8'(y);
    end
    return r;
  endfunction

  // Pulses start, optionally re-pulses it at edge pulse_at, and returns the
  // number of edges from the start edge until done is seen.
  task automatic run_eval(input string name, input int pulse_at, output int lat);
    drive_in_vec();
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    lat = 0;
    @(negedge clk);
    bus.start = 1'b0;
    vectors++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b1 || bus.outreg !== '0) begin
      errors++;
      $display("FAIL %s accept: done=%b busy=%b outreg=%h, required done=0 busy=1 outreg=0",
               name, bus.done, bus.busy, bus.outreg);
    end
    while (bus.done !== 1'b1 && lat < 200) begin
      bus.start = (pulse_at > 0) && (lat + 1 == pulse_at);
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    bus.start = 1'b0;
    vectors++;
    if (lat != LAT) begin
      errors++;
      $display("FAIL %s latency: got %0d edges, required %0d", name, lat, LAT);
    end
    vectors++;
    if (bus.tap_idx !== 3'd0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL %s at done: tap_idx=%0d busy=%b, required 0 and 0",
               name, bus.tap_idx, bus.busy);
    end
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    bus.start = 1'b0;
    load_uniform(0, 0, 0);
    drive_in_vec();
    repeat (3) @(negedge clk);
    vectors++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.outreg !== '0 ||
        bus.neuron_idx !== 4'd0 || bus.tap_idx !== 3'd0) begin
      errors++;
      $display("FAIL reset_state: done=%b busy=%b outreg=%h nidx=%0d tidx=%0d, required all 0",
               bus.done, bus.busy, bus.outreg, bus.neuron_idx, bus.tap_idx);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    vectors++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: done=%b busy=%b, required 0 0", bus.done, bus.busy);
    end
  endtask

  task automatic test_ones();
    int lat;
    load_uniform(1, 1, 0);
    run_eval("ones", 0, lat);
    vectors++;
    if (bus.outreg !== {NN{8'h00}}) begin
      errors++;
      $display("FAIL ones_result: got %h, required %h", bus.outreg, {NN{8'h00}});
    end
  endtask

  task automatic test_bias();
    int lat;
    load_uniform(16, 4, 2);
    run_eval("bias", 0, lat);
    vectors++;
    if (bus.outreg !== {NN{8'h12}}) begin
      errors++;
      $display("FAIL bias_result: got %h, required %h", bus.outreg, {NN{8'h12}});
    end
  endtask

  task automatic test_saturation();
    int lat;
    logic [8*NN-1:0] exp_neg;
`ifdef HIDDEN_RELU_EN
    exp_neg = {NN{8'h00}};
`else
    exp_neg = {NN{8'h80}};
`endif
    load_uniform(127, 127, 0);
    run_eval("sat_pos", 0, lat);
    vectors++;
    if (bus.outreg !== {NN{8'h7F}}) begin
      errors++;
      $display("FAIL sat_pos_result: got %h, required %h", bus.outreg, {NN{8'h7F}});
    end
    load_uniform(127, -127, 0);
    run_eval("sat_neg", 0, lat);
    vectors++;
    if (bus.outreg !== exp_neg) begin
      errors++;
      $display("FAIL sat_neg_result: got %h, required %h", bus.outreg, exp_neg);
    end
  endtask

  task automatic test_random();
    int lat;
    logic [8*NN-1:0] exp_r;
    for (int k = 0; k < 6; k++) begin
      load_random();
      exp_r = model();
      run_eval("random", 0, lat);
      vectors++;
      if (bus.outreg !== exp_r) begin
        errors++;
        $display("FAIL random_result[%0d]: got %h, required %h", k, bus.outreg, exp_r);
      end
    end
  endtask

  task automatic test_index_weights();
    int lat;
    logic [8*NN-1:0] exp_r;
    for (int i = 0; i < NI; i++) x_mem[i] = 8'($urandom_range(0, 255));
    for (int n = 0; n < 16; n++) begin
      b_mem[n] = 8'($urandom_range(0, 255));
      for (int t = 0; t < 8; t++) w_mem[n][t] = 8'(n + t);
    end
    exp_r = model();
    run_eval("idx_weights", 0, lat);
    for (int n = 0; n < NN; n++) begin
      vectors++;
      if (bus.outreg[n*8 +: 8] !== exp_r[n*8 +: 8]) begin
        errors++;
        $display("FAIL idx_weights neuron %0d: got %h, required %h",
                 n, bus.outreg[n*8 +: 8], exp_r[n*8 +: 8]);
      end
    end
  endtask

  task automatic test_start_ignored();
    int lat;
    logic [8*NN-1:0] exp_r;
    load_random();
    exp_r = model();
    run_eval("restart_ignored", 10, lat);
    vectors++;
    if (bus.outreg !== exp_r) begin
      errors++;
      $display("FAIL restart_ignored_result: got %h, required %h", bus.outreg, exp_r);
    end
  endtask

  // Starting from DONE: run_eval checks done drops on the accept edge.
  task automatic test_back_to_back();
    int lat;
    logic [8*NN-1:0] exp_r;
    vectors++;
    if (bus.done !== 1'b1) begin
      errors++;
      $display("FAIL b2b_precondition: done=%b, required 1", bus.done);
    end
    load_random();
    exp_r = model();
    run_eval("back_to_back", 0, lat);
    vectors++;
    if (bus.outreg !== exp_r) begin
      errors++;
      $display("FAIL back_to_back_result: got %h, required %h", bus.outreg, exp_r);
    end
  endtask

  task automatic test_reset_mid();
    bit done_seen;
    load_uniform(127, 127, 0);
    drive_in_vec();
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (24) @(posedge clk);
    @(negedge clk);
    vectors++;
    if (bus.outreg[7:0] !== 8'h7F || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_partial: byte0=%h done=%b, required 7f and 0",
               bus.outreg[7:0], bus.done);
    end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (bus.outreg !== '0 || bus.done !== 1'b0 || bus.busy !== 1'b0 ||
        bus.neuron_idx !== 4'd0 || bus.tap_idx !== 3'd0) begin
      errors++;
      $display("FAIL reset_mid_async: outreg=%h done=%b busy=%b nidx=%0d tidx=%0d, required all 0",
               bus.outreg, bus.done, bus.busy, bus.neuron_idx, bus.tap_idx);
    end
    @(negedge clk);
    rst_n = 1'b1;
    done_seen = 1'b0;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      if (bus.done === 1'b1 || bus.busy === 1'b1) done_seen = 1'b1;
    end
    vectors++;
    if (done_seen || bus.outreg !== '0) begin
      errors++;
      $display("FAIL reset_mid_abandon: activity=%b outreg=%h, required 0 and 0",
               done_seen, bus.outreg);
    end
  endtask

  initial begin
    test_reset();
    test_ones();
    test_bias();
    test_saturation();
    test_random();
    test_index_weights();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
